// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointed FE queue: entries read by the BE are held until committed so a
// rollback can replay them; a clear discards everything, including a same-cycle enqueue.
module bp_fe_queue_ckpt #(
   parameter int els_p   = 8,
   parameter int width_p = 128,
   localparam int ptr_width_lp = $clog2(els_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] fe_queue_i,
   input  logic               fe_queue_v_i,
   output logic               fe_queue_ready_o,
   output logic [width_p-1:0] fe_queue_o,
   output logic               fe_queue_v_o,
   input  logic               fe_queue_yumi_i,
   input  logic               cmt_v_i,
   input  logic               roll_v_i,
   input  logic               clr_v_i,
   output logic               empty_o
);

   localparam logic [ptr_width_lp:0] els_lp = (ptr_width_lp+1)'(els_p);
   localparam logic [ptr_width_lp:0] one_lp = (ptr_width_lp+1)'(1);

   logic [width_p-1:0]      mem_r [els_p];
   logic [ptr_width_lp:0]   wptr_r, rptr_r, cptr_r;
   logic [ptr_width_lp:0]   wptr_next, cptr_next, occupancy;
   logic                    full, enq, deq, cmt_ok;

   // Pointers carry a wrap bit, so the subtraction gives occupancy 0..els_p directly.
   assign occupancy        = wptr_r - cptr_r;
   assign full             = (occupancy == els_lp);
   assign fe_queue_ready_o = ~full;
   assign fe_queue_v_o     = (rptr_r != wptr_r);
   assign empty_o          = (cptr_r == wptr_r);
   assign fe_queue_o       = mem_r[rptr_r[ptr_width_lp-1:0]];

   assign enq       = fe_queue_v_i & ~full;
   assign deq       = fe_queue_yumi_i & fe_queue_v_o;
   assign cmt_ok    = cmt_v_i & (cptr_r != rptr_r);
   assign wptr_next = enq    ? wptr_r + one_lp : wptr_r;
   assign cptr_next = cmt_ok ? cptr_r + one_lp : cptr_r;

   always_ff @(posedge clk_i) begin
      if (enq)
         mem_r[wptr_r[ptr_width_lp-1:0]] <= fe_queue_i;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_next;
         if (clr_v_i) begin
            rptr_r <= wptr_next;
            cptr_r <= wptr_next;
         end else if (roll_v_i) begin
            rptr_r <= cptr_next;
            cptr_r <= cptr_next;
         end else begin
            if (deq)
               rptr_r <= rptr_r + one_lp;
            cptr_r <= cptr_next;
         end
      end
   end

`ifndef SYNTHESIS
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
      fe_queue_yumi_i |-> fe_queue_v_o);
   a_cmt_needs_read: assert property (@(posedge clk_i) disable iff (!reset_i)
      (cmt_v_i & ~clr_v_i) |-> (cptr_r != rptr_r));
   a_roll_clr_exclusive: assert property (@(posedge clk_i) disable iff (!reset_i)
      !(roll_v_i & clr_v_i));
`endif

endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// Directed bench for the checkpointed FE queue, 4-entry configuration.
module tb_bp_fe_queue_ckpt;

   localparam int els_lp   = 4;
   localparam int width_lp = 16;

   logic                clk_i = 1'b0;
   logic                reset_i = 1'b0;
   logic [width_lp-1:0] fe_queue_i = '0;
   logic                fe_queue_v_i = 1'b0;
   logic                fe_queue_ready_o;
   logic [width_lp-1:0] fe_queue_o;
   logic                fe_queue_v_o;
   logic                fe_queue_yumi_i = 1'b0;
   logic                cmt_v_i = 1'b0;
   logic                roll_v_i = 1'b0;
   logic                clr_v_i = 1'b0;
   logic                empty_o;

   int n_checks = 0;
   int n_fail   = 0;

   bp_fe_queue_ckpt #(.els_p(els_lp), .width_p(width_lp)) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .fe_queue_i(fe_queue_i),
      .fe_queue_v_i(fe_queue_v_i),
      .fe_queue_ready_o(fe_queue_ready_o),
      .fe_queue_o(fe_queue_o),
      .fe_queue_v_o(fe_queue_v_o),
      .fe_queue_yumi_i(fe_queue_yumi_i),
      .cmt_v_i(cmt_v_i),
      .roll_v_i(roll_v_i),
      .clr_v_i(clr_v_i),
      .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      fe_queue_v_i    = 1'b0;
      fe_queue_yumi_i = 1'b0;
      cmt_v_i         = 1'b0;
      roll_v_i        = 1'b0;
      clr_v_i         = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset_i = 1'b0;
      repeat (2) step();
      n_checks++;
      if (fe_queue_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got=%b exp=1", fe_queue_ready_o);
      end
      n_checks++;
      if (fe_queue_v_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_v got=%b exp=0", fe_queue_v_o);
      end
      n_checks++;
      if (empty_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_o);
      end
      reset_i = 1'b1;
      step();
   endtask

   task automatic test_order();
      logic [width_lp-1:0] exp_q [3] = '{16'hA00A, 16'hB00B, 16'hC00C};
      fe_queue_v_i = 1'b1; fe_queue_i = exp_q[0];
      n_checks++;
      if (fe_queue_v_o !== 1'b0) begin
         n_fail++; $display("FAIL order_no_bypass got=%b exp=0", fe_queue_v_o);
      end
      step();
      for (int i = 0; i < 3; i++) begin
         fe_queue_v_i = (i < 2); fe_queue_i = (i < 2) ? exp_q[i+1] : '0;
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_v_o !== 1'b1 || fe_queue_o !== exp_q[i]) begin
            n_fail++; $display("FAIL order_out%0d got v=%b d=%h exp v=1 d=%h", i, fe_queue_v_o, fe_queue_o, exp_q[i]);
         end
         step();
      end
      idle();
      n_checks++;
      if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b0) begin
         n_fail++; $display("FAIL order_drained got v=%b empty=%b exp v=0 empty=0", fe_queue_v_o, empty_o);
      end
      for (int i = 0; i < 3; i++) begin
         cmt_v_i = 1'b1;
         step();
         n_checks++;
         if (empty_o !== (i == 2)) begin
            n_fail++; $display("FAIL order_cmt%0d_empty got=%b exp=%b", i, empty_o, (i == 2));
         end
      end
      idle();
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = 16'h1000 + 16'(i);
         n_checks++;
         if (fe_queue_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_ready_before%0d got=%b exp=1", i, fe_queue_ready_o);
         end
         step();
      end
      fe_queue_i = 16'hDEAD;
      n_checks++;
      if (fe_queue_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL full_ready_after4 got=%b exp=0", fe_queue_ready_o);
      end
      step();
      fe_queue_v_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 16'h1000 + 16'(i)) begin
            n_fail++; $display("FAIL full_out%0d got v=%b d=%h exp v=1 d=%h", i, fe_queue_v_o, fe_queue_o, 16'h1000 + 16'(i));
         end
         step();
         n_checks++;
         if (fe_queue_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_yumi%0d got=%b exp=0", i, fe_queue_ready_o);
         end
      end
      idle();
      n_checks++;
      if (fe_queue_v_o !== 1'b0) begin
         n_fail++; $display("FAIL full_dropped_absent got=%b exp=0", fe_queue_v_o);
      end
      cmt_v_i = 1'b1;
      step();
      n_checks++;
      if (fe_queue_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL full_ready_cmt got=%b exp=1", fe_queue_ready_o);
      end
      repeat (3) step();
      idle();
      n_checks++;
      if (empty_o !== 1'b1) begin
         n_fail++; $display("FAIL full_drain_empty got=%b exp=1", empty_o);
      end
   endtask

   task automatic test_roll();
      logic [width_lp-1:0] d [4] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
      for (int i = 0; i < 4; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = d[i];
         step();
      end
      idle();
      for (int i = 0; i < 2; i++) begin
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_o !== d[i]) begin
            n_fail++; $display("FAIL roll_pre%0d got=%h exp=%h", i, fe_queue_o, d[i]);
         end
         step();
      end
      idle();
      // commit A together with the rollback: B must be the replay point
      cmt_v_i = 1'b1; roll_v_i = 1'b1;
      step();
      idle();
      n_checks++;
      if (fe_queue_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL roll_occ3_ready got=%b exp=1", fe_queue_ready_o);
      end
      for (int i = 1; i < 4; i++) begin
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_v_o !== 1'b1 || fe_queue_o !== d[i]) begin
            n_fail++; $display("FAIL roll_replay%0d got v=%b d=%h exp v=1 d=%h", i, fe_queue_v_o, fe_queue_o, d[i]);
         end
         step();
      end
      idle();
      cmt_v_i = 1'b1;
      repeat (3) step();
      idle();
      n_checks++;
      if (empty_o !== 1'b1 || fe_queue_v_o !== 1'b0) begin
         n_fail++; $display("FAIL roll_drain got empty=%b v=%b exp empty=1 v=0", empty_o, fe_queue_v_o);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = 16'h2000 + 16'(i);
         step();
      end
      fe_queue_v_i = 1'b1; fe_queue_i = 16'hEEEE; clr_v_i = 1'b1;
      step();
      idle();
      n_checks++;
      if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b1 || fe_queue_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL clear_state got v=%b empty=%b ready=%b exp v=0 empty=1 ready=1",
                            fe_queue_v_o, empty_o, fe_queue_ready_o);
      end
      step();
      fe_queue_v_i = 1'b1; fe_queue_i = 16'hF00F;
      step();
      idle();
      n_checks++;
      if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 16'hF00F) begin
         n_fail++; $display("FAIL clear_next got v=%b d=%h exp v=1 d=f00f", fe_queue_v_o, fe_queue_o);
      end
      fe_queue_yumi_i = 1'b1;
      step();
      idle();
      cmt_v_i = 1'b1;
      step();
      idle();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 11; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = 16'h3000 + 16'(i * 7);
         step();
         idle();
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 16'h3000 + 16'(i * 7)) begin
            n_fail++; $display("FAIL wrap_seq%0d got v=%b d=%h exp v=1 d=%h", i, fe_queue_v_o, fe_queue_o, 16'h3000 + 16'(i * 7));
         end
         step();
         idle();
         cmt_v_i = 1'b1;
         step();
         idle();
      end
      for (int i = 0; i < 4; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = 16'h4000 + 16'(i);
         step();
      end
      idle();
      n_checks++;
      if (fe_queue_ready_o !== 1'b0 || empty_o !== 1'b0) begin
         n_fail++; $display("FAIL wrap_full got ready=%b empty=%b exp ready=0 empty=0", fe_queue_ready_o, empty_o);
      end
      for (int i = 0; i < 4; i++) begin
         fe_queue_yumi_i = 1'b1;
         n_checks++;
         if (fe_queue_o !== 16'h4000 + 16'(i)) begin
            n_fail++; $display("FAIL wrap_fill%0d got=%h exp=%h", i, fe_queue_o, 16'h4000 + 16'(i));
         end
         step();
      end
      idle();
      cmt_v_i = 1'b1;
      repeat (4) step();
      idle();
      n_checks++;
      if (empty_o !== 1'b1 || fe_queue_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL wrap_empty got empty=%b ready=%b exp empty=1 ready=1", empty_o, fe_queue_ready_o);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         fe_queue_v_i = 1'b1; fe_queue_i = 16'h5000 + 16'(i);
         step();
      end
      idle();
      n_checks++;
      if (fe_queue_v_o !== 1'b1 || empty_o !== 1'b0) begin
         n_fail++; $display("FAIL arst_pre got v=%b empty=%b exp v=1 empty=0", fe_queue_v_o, empty_o);
      end
      #2 reset_i = 1'b0;
      #1;
      n_checks++;
      if (fe_queue_v_o !== 1'b0 || fe_queue_ready_o !== 1'b1 || empty_o !== 1'b1) begin
         n_fail++; $display("FAIL arst_immediate got v=%b ready=%b empty=%b exp v=0 ready=1 empty=1",
                            fe_queue_v_o, fe_queue_ready_o, empty_o);
      end
      step();
      reset_i = 1'b1;
      step();
      n_checks++;
      if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b1) begin
         n_fail++; $display("FAIL arst_post got v=%b empty=%b exp v=0 empty=1", fe_queue_v_o, empty_o);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_roll();
      test_clear();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
